// File: rtl/multicycle_sequencer_if.sv
// Handshake/control bundle between the multicycle sequencer and the datapath.
// master = sequencer side, slave = datapath / instruction register side.
interface multicycle_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic                run;
    logic [31:0]         instr;
    logic                mem_ready;
    logic                zero;
    logic [3:0]          ALU_OP;
    logic                Branch;
    logic                CNTRL_RS;
    logic                MEM_WS;
    logic                MEM_RS;
    logic                MEM_TR;
    logic                PC_WE;
    logic                IR_WE;
    logic                ALU_SRC;
    logic                REG_DST;
    logic [2:0]          state;
    logic [RETIRE_W-1:0] retired;
    logic                illegal;

    modport master (
        input  run, instr, mem_ready, zero,
        output ALU_OP, Branch, CNTRL_RS, MEM_WS, MEM_RS, MEM_TR,
        output PC_WE, IR_WE, ALU_SRC, REG_DST, state, retired, illegal
    );

    modport slave (
        output run, instr, mem_ready, zero,
        input  ALU_OP, Branch, CNTRL_RS, MEM_WS, MEM_RS, MEM_TR,
        input  PC_WE, IR_WE, ALU_SRC, REG_DST, state, retired, illegal
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer.
// Define SEQ_ILLEGAL_TRAP_EN to trap on unsupported encodings instead of NOP.
module multicycle_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.master bus
);
`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t              state_q;
    state_t              next_instr;
    logic [5:0]          op_q;
    logic [5:0]          func_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                illegal_q;

    logic [5:0] op_in;
    logic [5:0] func_in;
    logic       dec_ok;
    logic       is_r, is_addi, is_lw, is_sw, is_beq;
    logic       retire;
    logic [3:0] r_alu;
    logic       unused_instr;

    logic [3:0] alu_op;
    logic       branch, cntrl_rs, mem_ws, mem_rs, mem_tr;
    logic       pc_we, ir_we, alu_src, reg_dst;

    assign op_in        = bus.instr[31:26];
    assign func_in      = bus.instr[5:0];
    assign unused_instr = ^bus.instr[25:6];

    always_comb begin
        dec_ok = 1'b0;
        unique case (op_in)
            OP_R:   dec_ok = func_in inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI,
            OP_LW,
            OP_SW,
            OP_BEQ: dec_ok = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    // Later states decode from the op/func captured in DECODE, not live instr.
    assign is_r    = (op_q == OP_R);
    assign is_addi = (op_q == OP_ADDI);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);

    assign next_instr = bus.run ? FETCH : IDLE;

    always_comb begin
        r_alu = ALU_AND;
        unique case (func_q)
            F_ADD:   r_alu = ALU_ADD;
            F_SUB:   r_alu = ALU_SUB;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_SLT:   r_alu = ALU_SLT;
            default: r_alu = ALU_AND;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            DECODE:    retire = !dec_ok && !TRAP_EN;
            EXECUTE:   retire = is_beq;
            MEMORY:    retire = is_sw && bus.mem_ready;
            WRITEBACK: retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            func_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire)
                retired_q <= retired_q + RETIRE_W'(1);
            unique case (state_q)
                IDLE:
                    if (bus.run) state_q <= FETCH;
                FETCH:
                    if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    op_q   <= op_in;
                    func_q <= func_in;
                    if (dec_ok) begin
                        state_q <= EXECUTE;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= TRAP_EN ? TRAP : next_instr;
                    end
                end
                EXECUTE:
                    if (is_beq)              state_q <= next_instr;
                    else if (is_lw || is_sw) state_q <= MEMORY;
                    else                     state_q <= WRITEBACK;
                MEMORY:
                    if (bus.mem_ready)
                        state_q <= is_lw ? WRITEBACK : next_instr;
                WRITEBACK:
                    state_q <= next_instr;
                TRAP:
                    state_q <= TRAP;
                default:
                    state_q <= IDLE;
            endcase
        end
    end

    // Moore decode, except the FETCH strobes gated by mem_ready and BEQ PC_WE.
    always_comb begin
        alu_op   = ALU_AND;
        branch   = 1'b0;
        cntrl_rs = 1'b0;
        mem_ws   = 1'b0;
        mem_rs   = 1'b0;
        mem_tr   = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        alu_src  = 1'b0;
        reg_dst  = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_rs = 1'b1;
                ir_we  = bus.mem_ready;
                pc_we  = bus.mem_ready;
            end
            EXECUTE: begin
                unique case (1'b1)
                    is_r:
                        alu_op = r_alu;
                    is_beq: begin
                        alu_op = ALU_SUB;
                        branch = 1'b1;
                        pc_we  = bus.zero;
                    end
                    is_addi, is_lw, is_sw: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEMORY: begin
                mem_rs = is_lw;
                mem_ws = is_sw;
            end
            WRITEBACK: begin
                cntrl_rs = 1'b1;
                reg_dst  = is_r;
                mem_tr   = is_lw;
            end
            default: ;
        endcase
    end

    assign bus.ALU_OP   = alu_op;
    assign bus.Branch   = branch;
    assign bus.CNTRL_RS = cntrl_rs;
    assign bus.MEM_WS   = mem_ws;
    assign bus.MEM_RS   = mem_rs;
    assign bus.MEM_TR   = mem_tr;
    assign bus.PC_WE    = pc_we;
    assign bus.IR_WE    = ir_we;
    assign bus.ALU_SRC  = alu_src;
    assign bus.REG_DST  = reg_dst;
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the custom CPU. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. In each state it drives the same control signal set the single-cycle decoder produces (ALU_OP, Branch, CNTRL_RS, MEM_WS, MEM_RS, MEM_TR, PC_WE), plus instruction-register and operand-select strobes. It sits between the instruction register and the shared datapath, and waits on a single-port memory ready handshake.

## Interface
- RETIRE_W, 16, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- run  in  1  level; 1 = fetch and execute, 0 = stop at next instruction boundary
- instr  in  32  instruction register contents; op = instr[31:26], func = instr[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  ALU zero flag, valid in EXECUTE
- ALU_OP  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- Branch  out  1  BEQ compare in progress
- CNTRL_RS  out  1  register file write enable
- MEM_WS  out  1  memory write strobe
- MEM_RS  out  1  memory read strobe
- MEM_TR  out  1  register write data comes from memory
- PC_WE  out  1  program counter load
- IR_WE  out  1  instruction register load
- ALU_SRC  out  1  ALU B operand = sign-extended immediate
- REG_DST  out  1  write register = rd (1) or rt (0)
- state  out  3  current state: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, TRAP 6
- retired  out  RETIRE_W  count of completed instructions; wraps to 0 after all-ones
- illegal  out  1  sticky flag for an unsupported op/func

## Operation
- Supported instructions:
  - R-type op 000000: ADD func 100000, SUB 100010, AND 100100, OR 100101, SLT 101010
  - ADDI 001000, LW 100011, SW 101011, BEQ 000100
- IDLE:
  - all strobes 0
  - run=1 → FETCH
- FETCH:
  - MEM_RS=1
  - mem_ready=0: hold FETCH
  - mem_ready=1: IR_WE=1 and PC_WE=1 (PC+4) in the same cycle, → DECODE
- DECODE:
  - latch op/func from instr into internal registers; the outputs in EXECUTE, MEMORY and WRITEBACK decode from these latched values
  - → EXECUTE, or TRAP/skip on an illegal encoding (see Configuration)
- EXECUTE:
  - R-type: ALU_OP per func; → WRITEBACK
  - ADDI: ALU_OP=ADD, ALU_SRC=1; → WRITEBACK
  - LW/SW: ALU_OP=ADD, ALU_SRC=1; → MEMORY
  - BEQ: ALU_OP=SUB, Branch=1, PC_WE=zero; instruction retires; → FETCH (or IDLE if run=0)
- MEMORY:
  - LW: MEM_RS=1; SW: MEM_WS=1
  - hold the strobe until mem_ready
  - on mem_ready: LW → WRITEBACK; SW retires → FETCH/IDLE
- WRITEBACK:
  - CNTRL_RS=1
  - REG_DST=1 for R-type; MEM_TR=1 for LW
  - retires → FETCH/IDLE
- run is sampled only at retirement and in IDLE; deasserting it never aborts an instruction in flight.
- retired increments by exactly 1 on the cycle an instruction leaves its final state.
- Outputs are Moore decodes of state and latched op/func, except:
  - PC_WE/IR_WE in FETCH, which are gated by mem_ready
  - PC_WE in BEQ EXECUTE, which follows zero
- Every strobe not listed for a state is 0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, retired=0, illegal=0, latched op/func=0
  - all strobes 0, ALU_OP=0000
- Cycles per instruction with zero-wait memory (mem_ready=1 on first request), counting FETCH through retirement:
  - R-type/ADDI 4, LW 5, SW 4, BEQ 3
- Each memory wait cycle adds exactly one cycle; the strobe stays high and stable through the wait.
- IDLE→FETCH takes one cycle after run is seen high. Back-to-back instructions have no bubble: the retire cycle is followed directly by FETCH.
- Reset asserted mid-MEMORY drops MEM_WS/MEM_RS combinationally; no partial write completes after reset.

## Configuration
- SEQ_ILLEGAL_TRAP_EN defined:
  - an unsupported op/func in DECODE sets illegal=1 and → TRAP
  - TRAP drives all strobes 0 and is left only by rst
  - retired does not increment
- SEQ_ILLEGAL_TRAP_EN undefined:
  - an unsupported encoding executes as a NOP: DECODE → FETCH/IDLE with no strobes
  - retired increments; illegal=1 is still set (sticky)
  - TRAP is unreachable

## Test plan
- Reset, run=1, mem_ready=1, instr=ADD (op 000000, func 100000) → states 1,2,3,5; ALU_OP=0010 in EXECUTE; CNTRL_RS=1 and REG_DST=1 in WRITEBACK; retired=1 after 4 cycles.
- LW with mem_ready low for 2 cycles in MEMORY → MEM_RS held 3 cycles; MEM_TR=1 and CNTRL_RS=1 in WRITEBACK; 7 cycles total.
- BEQ with zero=1, then BEQ with zero=0 → ALU_OP=0110 and Branch=1 in EXECUTE; PC_WE=1 in the first EXECUTE only; each takes 3 cycles.
- SW, then deassert run during MEMORY → MEM_WS=1 until mem_ready, never CNTRL_RS; state goes to IDLE after the retire; retired=1.
- Illegal op 111111 → with SEQ_ILLEGAL_TRAP_EN: state=6, illegal=1, retired unchanged; without: NOP, retired+1, illegal=1.
- Assert rst mid-FETCH wait, and preload retired=all-ones then retire one instruction → immediate IDLE with all outputs 0; counter wraps to 0.
